enc_gray_arb: RTL and testbench
===============================

# enc_gray_arb

Round-robin arbiter and sequencer that shares one binary-to-Gray encoder among `N_REQ` requesters. Each requester presents a binary word over a valid/ready handshake. The block grants one requester per cycle, encodes its word, and delivers the Gray result on a single registered output port tagged with the requester ID, honouring backpressure. It sits between pointer/counter producers (FIFO write/read pointers, position counters) and their clock-domain-crossing logic.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 10: data width in bits.
- `CNT_W`, 16: width of the per-requester conversion counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  grant enable; when low no new grants are issued, but the output still drains.
- `req_valid`  in  `N_REQ`  per-requester valid.
- `req_bin`  in  `N_REQ*W`  packed binary words; requester i occupies bits [i*W +: W].
- `req_ready`  out  `N_REQ`  one-hot grant/accept.
- `out_valid`  out  1  Gray result valid.
- `out_gray`  out  `W`  Gray code, equal to bin ^ (bin >> 1).
- `out_id`  out  `$clog2(N_REQ)`  index of the granted requester.
- `out_ready`  in  1  downstream accept.
- `conv_cnt`  out  `N_REQ*CNT_W`  per-requester accepted-conversion counters; wrap modulo 2^`CNT_W`.

## Operation
- `load` = `en` && (!`out_valid` || `out_ready`).
- Arbitration is combinational round-robin over `req_valid`, starting the search at priority pointer `ptr`.
- `req_ready[i]` is 1 only for the single winning i, and only when `load` is high. The grant depends combinationally on `req_valid`.
- On a handshake (`req_valid[i]` && `req_ready[i]`):
  - `out_gray` is loaded with the encoded word.
  - `out_id` is loaded with i.
  - `out_valid` is set to 1.
  - `ptr` is set to (i+1) mod `N_REQ`.
  - `conv_cnt[i]` increments.
- If `out_valid` && `out_ready` and there is no new handshake, `out_valid` clears. `out_gray` and `out_id` hold their last values.
- If `out_valid` && !`out_ready`:
  - all output registers hold;
  - `req_ready` is all zero;
  - `ptr` is unchanged.
- Requesters must hold `req_valid` and the data stable until accepted. The block does not check this.
- When `en` is low, in-flight output still completes normally. `ptr` does not change.
- Encoding rule:
  - `gray[W-1]` = `bin[W-1]`.
  - `gray[k]` = `bin[k+1]` ^ `bin[k]` for k < W-1.
  - No bit is forced to a constant.
- Reset (asynchronous, takes effect immediately, also mid-transfer):
  - `out_valid`=0, `out_gray`=0, `out_id`=0.
  - `ptr`=0.
  - all `conv_cnt` fields = 0.
  - A transfer in flight is dropped.

## Timing
- Latency is 1 cycle: a handshake at edge T makes `out_valid` visible after T.
- Throughput is one conversion per cycle while `out_ready` stays high.
- `req_ready` is combinational from `req_valid`, `en`, `out_valid`, `out_ready` and `ptr`.
- `out_*` are driven directly from registers, with no combinational path from inputs.
- When the output is consumed in the same cycle a new word is loaded, `out_valid` stays at 1 with no bubble.

## Structure
- A shared package `enc_pkg` holds:
  - the default `W` and `N_REQ` constants;
  - the `id_t` typedef;
  - the function `bin2gray(bin)` implementing bin ^ (bin >> 1).
- Sub-module `enc_rr_arb` (request vector + pointer -> one-hot grant and encoded index) is instantiated once.
- The encoder is the package function, not a separate instance.

## Test plan
- Reset, then requester 0 only with `bin`=0x3FF and `out_ready`=1: next cycle `out_gray`=0x200, `out_id`=0, `conv_cnt[0]`=1.
- All four requesters valid with `bin` = 0x155, 0x2AA, 0x010, 0x000, `out_ready`=1: grants go 0,1,2,3 on consecutive cycles; outputs are 0x1FF, 0x3FF, 0x018, 0x000; `out_valid` is continuous.
- Backpressure: `out_ready`=0 for 3 cycles with an output pending: `out_gray`/`out_id` are stable, `req_ready`=0. `out_ready`=1 then accepts the next requester after the previous winner.
- `en`=0 with requests pending: no `req_ready`, the pending output drains. `en`=1 resumes from the unchanged `ptr`.
- `rst_n` pulsed low asynchronously while `out_valid`=1: outputs go to 0 immediately, `ptr`=0, counters clear.
- Counter wrap with `CNT_W`=4: 17 accepts from requester 1 -> `conv_cnt[1]`=1.

Source files
------------

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants, id type and Gray encoder function
package enc_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int W_DEF      = 10;
  localparam int GRAY_MAX_W = 32;

  typedef logic [$clog2(N_REQ_DEF)-1:0] id_t;

  // Callers zero-extend narrower words; the zero top bit keeps gray[W-1] = bin[W-1].
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/enc_rr_arb.sv
// rtl/enc_rr_arb.sv - combinational round-robin arbiter, one-hot grant plus index
module enc_rr_arb
  import enc_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  // Search from the priority pointer upward, wrapping; first requester found wins.
  always_comb begin
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(i_ptr) + k) % N_REQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/enc_gray_arb.sv
// rtl/enc_gray_arb.sv - round-robin shared binary-to-Gray encoder with tagged registered output
module enc_gray_arb
  import enc_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_bin,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_gray,
  output logic [$clog2(N_REQ)-1:0] out_id,
  input  logic                     out_ready,
  output logic [N_REQ*CNT_W-1:0]   conv_cnt
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]      w_grant;
  logic [ID_W-1:0]       w_idx;
  logic                  w_any;
  logic                  w_load;
  logic                  w_hs;
  logic [W-1:0]          w_sel_bin;
  logic [GRAY_MAX_W-1:0] w_gray_full;
  logic [W-1:0]          w_gray;
  logic [ID_W-1:0]       w_ptr_nxt;

  logic [ID_W-1:0]       r_ptr;
  logic                  r_out_valid;
  logic [W-1:0]          r_out_gray;
  logic [ID_W-1:0]       r_out_id;
  logic [CNT_W-1:0]      r_cnt [N_REQ];

  enc_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A new word may enter only when the output slot is empty or being drained this cycle.
  assign w_load    = en && (!r_out_valid || out_ready);
  assign req_ready = w_load ? w_grant : '0;
  assign w_hs      = w_load && w_any;

  assign w_sel_bin   = req_bin[int'(w_idx)*W +: W];
  assign w_gray_full = bin2gray(GRAY_MAX_W'(w_sel_bin));
  assign w_gray      = w_gray_full[W-1:0];
  assign w_ptr_nxt   = (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + ID_W'(1);

  // Output register and priority pointer: load on handshake, clear valid on drain-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_gray  <= '0;
      r_out_id    <= '0;
      r_ptr       <= '0;
    end else if (w_hs) begin
      r_out_valid <= 1'b1;
      r_out_gray  <= w_gray;
      r_out_id    <= w_idx;
      r_ptr       <= w_ptr_nxt;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Per-requester accepted-conversion counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (w_hs && (w_idx == ID_W'(i))) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign conv_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign out_valid = r_out_valid;
  assign out_gray  = r_out_gray;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_enc_gray_arb.sv
// tb/tb_enc_gray_arb.sv - directed self-checking bench for enc_gray_arb
module tb_enc_gray_arb;

  localparam int N_REQ = 4;
  localparam int W     = 10;
  localparam int CNT_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   en;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*W-1:0]     req_bin;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [W-1:0]           out_gray;
  logic [1:0]             out_id;
  logic                   out_ready;
  logic [N_REQ*CNT_W-1:0] conv_cnt;

  int n_tests;
  int n_fail;

  enc_gray_arb #(
    .N_REQ (N_REQ),
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .out_ready (out_ready),
    .conv_cnt  (conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req_valid = '0; req_bin = '0; out_ready = 1'b1;
    tick(); tick();
    n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %0h want 0", out_valid); end
    n_tests++; if (out_gray !== 10'h0)  begin n_fail++; $display("FAIL reset_gray got %0h want 0", out_gray); end
    n_tests++; if (out_id !== 2'd0)     begin n_fail++; $display("FAIL reset_id got %0d want 0", out_id); end
    n_tests++; if (conv_cnt !== 16'h0)  begin n_fail++; $display("FAIL reset_cnt got %0h want 0", conv_cnt); end
    n_tests++; if (req_ready !== 4'b0)  begin n_fail++; $display("FAIL reset_ready got %0b want 0", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_bin[0*W +: W] = 10'h3FF;
    req_valid = 4'b0001; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %0b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL single_valid got %0h want 1", out_valid); end
    n_tests++; if (out_gray !== 10'h200) begin n_fail++; $display("FAIL single_gray got %0h want 200", out_gray); end
    n_tests++; if (out_id !== 2'd0)      begin n_fail++; $display("FAIL single_id got %0d want 0", out_id); end
    n_tests++; if (conv_cnt[3:0] !== 4'd1) begin n_fail++; $display("FAIL single_cnt got %0d want 1", conv_cnt[3:0]); end
    tick();
    n_tests++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL single_drain got %0h want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_g [4];
    exp_g[0] = 10'h1FF; exp_g[1] = 10'h3FF; exp_g[2] = 10'h018; exp_g[3] = 10'h000;
    do_reset();
    req_bin = {10'h000, 10'h010, 10'h2AA, 10'h155};
    req_valid = 4'b1111; out_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (req_ready !== 4'(1 << i)) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0b want %0b", i, req_ready, 4'(1 << i)); end
      tick();
      req_valid[i] = 1'b0; #1;
      n_tests++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL b2b_valid[%0d] got %0h want 1", i, out_valid); end
      n_tests++; if (out_gray !== exp_g[i]) begin n_fail++; $display("FAIL b2b_gray[%0d] got %0h want %0h", i, out_gray, exp_g[i]); end
      n_tests++; if (out_id !== 2'(i))      begin n_fail++; $display("FAIL b2b_id[%0d] got %0d want %0d", i, out_id, i); end
    end
    n_tests++; if (conv_cnt !== 16'h1111) begin n_fail++; $display("FAIL b2b_cnt got %0h want 1111", conv_cnt); end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010; out_ready = 1'b1; #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first_ready got %0b want 0010", req_ready); end
    tick();
    req_valid = 4'b0101; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (req_ready !== 4'b0)   begin n_fail++; $display("FAIL bp_ready[%0d] got %0b want 0", c, req_ready); end
      n_tests++; if (out_gray !== 10'h3FF) begin n_fail++; $display("FAIL bp_gray[%0d] got %0h want 3ff", c, out_gray); end
      n_tests++; if (out_id !== 2'd1)      begin n_fail++; $display("FAIL bp_id[%0d] got %0d want 1", c, out_id); end
      n_tests++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_valid[%0d] got %0h want 1", c, out_valid); end
      tick();
    end
    out_ready = 1'b1; #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_resume_ready got %0b want 0100", req_ready); end
    tick();
    req_valid = 4'b0001; #1;
    n_tests++; if (out_id !== 2'd2 || out_gray !== 10'h018) begin n_fail++; $display("FAIL bp_resume_out got id %0d gray %0h want id 2 gray 018", out_id, out_gray); end
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_wrap_ready got %0b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (out_id !== 2'd0 || out_gray !== 10'h1FF) begin n_fail++; $display("FAIL bp_wrap_out got id %0d gray %0h want id 0 gray 1ff", out_id, out_gray); end
    tick();
    n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL bp_drain got %0h want 0", out_valid); end
    n_tests++; if (conv_cnt !== 16'h1222) begin n_fail++; $display("FAIL bp_cnt got %0h want 1222", conv_cnt); end
  endtask

  task automatic test_enable();
    req_valid = 4'b0010; en = 1'b1; out_ready = 1'b1;
    tick();
    en = 1'b0; out_ready = 1'b0; req_valid = 4'b1111; #1;
    n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL en_hold_ready got %0b want 0", req_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin n_fail++; $display("FAIL en_hold_out got v %0h id %0d want v 1 id 1", out_valid, out_id); end
    out_ready = 1'b1; #1;
    n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL en_drain_ready got %0b want 0", req_ready); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_drain got %0h want 0", out_valid); end
    n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL en_idle_ready got %0b want 0", req_ready); end
    en = 1'b1; #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL en_resume_ready got %0b want 0100", req_ready); end
    tick();
    req_valid = '0;
    n_tests++; if (out_id !== 2'd2 || out_gray !== 10'h018) begin n_fail++; $display("FAIL en_resume_out got id %0d gray %0h want id 2 gray 018", out_id, out_gray); end
    n_tests++; if (conv_cnt !== 16'h1332) begin n_fail++; $display("FAIL en_cnt got %0h want 1332", conv_cnt); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0 || out_gray !== 10'h0 || out_id !== 2'd0) begin n_fail++; $display("FAIL arst_out got v %0h gray %0h id %0d want 0 0 0", out_valid, out_gray, out_id); end
    n_tests++; if (conv_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_cnt got %0h want 0", conv_cnt); end
    #1 rst_n = 1'b1;
    req_valid = 4'b1111; #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_ptr got ready %0b want 0001", req_ready); end
    req_valid = '0;
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_idle got %0h want 0", out_valid); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    req_valid = 4'b0010; out_ready = 1'b1; en = 1'b1;
    for (int c = 0; c < 17; c++) tick();
    req_valid = '0;
    n_tests++; if (conv_cnt !== 16'h0010) begin n_fail++; $display("FAIL wrap_cnt got %0h want 0010", conv_cnt); end
    n_tests++; if (out_gray !== 10'h3FF || out_id !== 2'd1) begin n_fail++; $display("FAIL wrap_out got gray %0h id %0d want 3ff 1", out_gray, out_id); end
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
